// File: rtl/oreg_uart_tx.sv
// 8N1 UART transmitter fed by an output-register write strobe.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module oreg_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_overflow;

  logic        w_push, w_pop, w_empty, w_full, w_bit_end;
  logic [7:0]  w_head;

  // Space is judged on pre-edge occupancy; a same-cycle pop never frees room.
  assign w_push = wr_en && !w_full;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_vld;

  assign w_empty = !r_hold_vld;
  // FIFO_DEPTH does not size anything in this build.
  assign w_full  = r_hold_vld && (FIFO_DEPTH != 0);
  assign w_head  = r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold     <= wr_data;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
`endif

  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          // Back-to-back frames: pop on the last stop cycle, no idle gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_oreg_uart_tx.sv
// Bench for oreg_uart_tx: directed scenarios plus random traffic against a frame-level model.
module tb_oreg_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       tx, busy, full, overflow;

  int checks = 0;
  int errors = 0;

  // Model: pending bytes, position inside the current frame (-1 = line idle), sticky drop flag.
  logic [7:0] q[$];
  int         fk = -1;
  logic [7:0] fb = '0;
  logic       ovf = 1'b0;

  oreg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (fk < 0) return 1'b1;
    b = fk / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return fb[b-1];
  endfunction

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic full_b;
    wr_en = w; wr_data = d; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete(); fk = -1; ovf = 1'b0;
    end else begin
      full_b = (q.size() >= CAP);
      if (w && full_b) ovf = 1'b1;
      if (fk < 0 || fk == FRAME - 1) begin
        if (q.size() > 0) begin
          fb = q.pop_front(); fk = 0;
        end else fk = -1;
      end else fk++;
      if (w && !full_b) q.push_back(d);
    end
    #1;
    wr_en = 1'b0; rst = 1'b0;
    chk("tx", tx, exp_tx());
    chk("busy", busy, (fk >= 0) || (q.size() > 0));
    chk("full", full, q.size() == CAP);
    chk("overflow", overflow, ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [9:0] fr;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    idle(3);

    // Single 0xA5 frame against a fixed waveform.
    fr = {1'b1, 8'hA5, 1'b0};
    step(1'b1, 8'hA5, 1'b0);
    for (int n = 0; n < FRAME; n++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("a5_tx", tx, fr[n / CPB]);
      chk("a5_busy", busy, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0);
    chk("a5_idle_busy", busy, 1'b0);
    chk("a5_idle_tx", tx, 1'b1);
    idle(3);

    // Three consecutive writes.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
`ifdef UART_TX_FIFO_EN
    chk("b2b_ovf", overflow, 1'b0);
`else
    chk("hold_ovf", overflow, 1'b1);
`endif
    idle(3 * FRAME + 5);
    step(1'b0, 8'h00, 1'b1);

    // Six-write burst: exercises full and the drop path.
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
`ifdef UART_TX_FIFO_EN
        chk("burst_full6", full, 1'b1);
`endif
      end
      step(1'b1, 8'(8'h10 + i), 1'b0);
    end
    chk("burst_ovf", overflow, 1'b1);
    idle(6 * FRAME);
    chk("burst_ovf_sticky", overflow, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-frame with bytes still queued.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
`ifdef UART_TX_FIFO_EN
    step(1'b1, 8'hBB, 1'b0);
`endif
    for (int i = 0; i < FRAME && fk != 14; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("midrst_quiet", tx, 1'b1);
    end
    chk("midrst_ovf", overflow, 1'b0);

    // Reset beats a same-cycle write.
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("rstwr_tx", tx, 1'b1);
    end
    chk("rstwr_busy", busy, 1'b0);

    // Random traffic with occasional bursts and resets.
    for (int i = 0; i < 1500; i++) begin
      int unsigned p;
      p = $urandom_range(0, 99);
      if (p == 0)       step(1'b0, 8'h00, 1'b1);
      else if (p < 5)   step(1'b1, 8'($urandom), 1'b0);
      else if (p < 8) begin
        for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom), 1'b0);
      end else          step(1'b0, 8'h00, 1'b0);
    end
    idle(6 * FRAME);
    chk("end_busy", busy, 1'b0);
    chk("end_tx", tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
